// File: rtl/phys_free_list_pkg.sv
// phys_free_list_pkg: sizing shared by the frontend, the ROB and the physical-register free list.
package phys_free_list_pkg;
  localparam int PR_ADDR_W    = 6;
  localparam int NUM_PREGS    = 64;
  localparam int NUM_RESERVED = 16;
  localparam int FREE_W       = 6;
  localparam int ALLOC_W      = 4;
  localparam int FREE_CT_W    = $clog2(FREE_W) + 1;
  localparam int ALLOC_CT_W   = $clog2(ALLOC_W) + 1;
  localparam int CNT_W        = PR_ADDR_W + 1;
  typedef logic [PR_ADDR_W-1:0]  preg_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [FREE_CT_W-1:0]  free_ct_t;
  typedef logic [ALLOC_CT_W-1:0] alloc_ct_t;
endpackage

// File: rtl/phys_free_list_sat_min.sv
// sat_min: combinational minimum of two unsigned counts, result narrowed to the second operand's width.
module sat_min #(
  parameter int WA = 4,
  parameter int WB = 4
) (
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  output logic [WB-1:0] y
);
  assign y = (a < WA'(b)) ? WB'(a) : b;
endmodule

// File: rtl/phys_free_list.sv
// phys_free_list: circular free list of physical registers between ROB commit and rename.
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FREE_W*PR_ADDR_W-1:0]  free_in,
  input  logic [FREE_CT_W-1:0]         free_in_valid_ct,
  output logic [FREE_CT_W-1:0]         free_in_ready_ct,
  output logic [ALLOC_W*PR_ADDR_W-1:0] alloc_out,
  output logic [ALLOC_CT_W-1:0]        alloc_valid_ct,
  input  logic [ALLOC_CT_W-1:0]        alloc_take_ct,
  output logic [CNT_W-1:0]             free_count,
  output logic                         err
);
  preg_t     entry [NUM_PREGS];
  preg_t     head, tail;
  cnt_t      count, space;
  free_ct_t  push;
  alloc_ct_t take;
  assign space      = cnt_t'(NUM_PREGS) - count;
  assign free_count = count;
  sat_min #(.WA(CNT_W), .WB(FREE_CT_W)) u_ready (
    .a(space), .b(free_ct_t'(FREE_W)), .y(free_in_ready_ct)
  );
  sat_min #(.WA(CNT_W), .WB(ALLOC_CT_W)) u_valid (
    .a(count), .b(alloc_ct_t'(ALLOC_W)), .y(alloc_valid_ct)
  );
  sat_min #(.WA(FREE_CT_W), .WB(FREE_CT_W)) u_push (
    .a(free_in_valid_ct), .b(free_in_ready_ct), .y(push)
  );
  sat_min #(.WA(ALLOC_CT_W), .WB(ALLOC_CT_W)) u_take (
    .a(alloc_take_ct), .b(alloc_valid_ct), .y(take)
  );
  for (genvar k = 0; k < ALLOC_W; k++) begin : g_alloc
    assign alloc_out[k*PR_ADDR_W +: PR_ADDR_W] = entry[head + preg_t'(k)];
  end
  // Valid and free regions are disjoint pre-edge, so pushes never hit slots being read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) entry[i] <= preg_t'(NUM_RESERVED + i);
      head  <= '0;
      tail  <= preg_t'(NUM_PREGS - NUM_RESERVED);
      count <= cnt_t'(NUM_PREGS - NUM_RESERVED);
      err   <= 1'b0;
    end else begin
      for (int j = 0; j < FREE_W; j++)
        if (free_ct_t'(j) < push) entry[tail + preg_t'(j)] <= free_in[j*PR_ADDR_W +: PR_ADDR_W];
      head  <= head + preg_t'(take);
      tail  <= tail + preg_t'(push);
      count <= count + cnt_t'(push) - cnt_t'(take);
      err   <= err | (alloc_take_ct > alloc_valid_ct) | (free_in_valid_ct > free_in_ready_ct);
    end
  end
endmodule
